// File: rtl/uart_pkg.sv
// Shared UART definitions: ASCII control codes, parser state encoding, default widths.
// Latency: none (declarations only).
// Backpressure: not applicable.
package uart_pkg;

  localparam int DEFAULT_HEX_SIZE   = 4;
  localparam int DEFAULT_ASCII_SIZE = 8;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FLUSH   = 2'd2
  } parse_state_t;

  function automatic logic is_term(input logic [7:0] c);
    return (c == ASCII_CR) || (c == ASCII_LF);
  endfunction

endpackage

// File: rtl/ascii_to_hex.sv
// ASCII character to hex nibble decoder (inverse of the hex-to-ASCII converter).
// Latency: combinational.
// Backpressure: not applicable.
// Ports: ascii_in - character; hex_out - nibble value (0 when not a digit);
//        is_hex - ascii_in is 0-9, A-F or a-f.
module ascii_to_hex (
  input  logic [7:0] ascii_in,
  output logic [3:0] hex_out,
  output logic       is_hex
);

  always_comb begin
    hex_out = 4'h0;
    is_hex  = 1'b0;
    if (ascii_in >= 8'h30 && ascii_in <= 8'h39) begin
      // '0'..'9': low nibble is the value
      is_hex  = 1'b1;
      hex_out = ascii_in[3:0];
    end else if ((ascii_in >= 8'h41 && ascii_in <= 8'h46) ||
                 (ascii_in >= 8'h61 && ascii_in <= 8'h66)) begin
      // 'A'..'F' / 'a'..'f': low nibble is 1..6, value is 10..15
      is_hex  = 1'b1;
      hex_out = ascii_in[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/uart_input_manager.sv
// Parses CR/LF-terminated lines of ASCII hex digits from the UART RX into a word.
// Latency: ready_out pulses one clk after the terminator (or timeout expiry) is sampled.
// Backpressure: none; every ready_out pulse must be accepted downstream.
// Ports: clk, reset (sync, active-high); rx_valid/rx_data/rx_frame_err from the UART RX;
//        ready_out one-cycle pulse qualifying data_out (zero-extended value) and error_out,
//        both held until the next pulse.
module uart_input_manager
  import uart_pkg::*;
#(
  parameter int RESULT_SIZE    = 4,
  parameter int HEX_SIZE       = DEFAULT_HEX_SIZE,
  parameter int ASCII_SIZE     = DEFAULT_ASCII_SIZE,
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            rx_valid,
  input  logic [ASCII_SIZE-1:0]           rx_data,
  input  logic                            rx_frame_err,
  output logic                            ready_out,
  output logic [RESULT_SIZE*HEX_SIZE-1:0] data_out,
  output logic                            error_out
);

  localparam int DATA_W = RESULT_SIZE * HEX_SIZE;
  localparam int CNT_W  = $clog2(RESULT_SIZE + 1);

  parse_state_t      state, state_nxt;
  logic [DATA_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              emit_data, emit_err;
  logic              timeout_hit;

  logic [3:0] hex_nibble;
  logic       is_hex;

  ascii_to_hex u_ascii_to_hex (
    .ascii_in (rx_data),
    .hex_out  (hex_nibble),
    .is_hex   (is_hex)
  );

  // A framing error demotes any character, including CR/LF, to invalid.
  logic ch_digit, ch_term;
  assign ch_digit = is_hex && !rx_frame_err;
  assign ch_term  = is_term(rx_data) && !rx_frame_err;

  // Inter-character timeout; the expiry cycle is the one where the counter
  // already equals TIMEOUT_CYCLES and no character arrives.
  if (TIMEOUT_CYCLES > 0) begin : g_tmo
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;

    assign timeout_hit = (state != IDLE) && !rx_valid &&
                         (tmo_cnt == TMO_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
      if (reset || state == IDLE || rx_valid || timeout_hit)
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end else begin : g_no_tmo
    assign timeout_hit = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    emit_data = 1'b0;
    emit_err  = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          if (ch_digit) begin
            acc_nxt   = {acc[DATA_W-HEX_SIZE-1:0], HEX_SIZE'(hex_nibble)};
            cnt_nxt   = CNT_W'(1);
            state_nxt = COLLECT;
          end else if (!ch_term) begin
            state_nxt = FLUSH;
          end
          // bare terminators (CRLF tail, empty lines) are ignored
        end
      end
      COLLECT: begin
        if (timeout_hit) begin
          emit_err  = 1'b1;
          state_nxt = IDLE;
        end else if (rx_valid) begin
          if (ch_digit) begin
            if (cnt < CNT_W'(RESULT_SIZE)) begin
              acc_nxt = {acc[DATA_W-HEX_SIZE-1:0], HEX_SIZE'(hex_nibble)};
              cnt_nxt = cnt + CNT_W'(1);
            end else begin
              state_nxt = FLUSH;
            end
          end else if (ch_term) begin
            emit_data = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (timeout_hit || (rx_valid && ch_term)) begin
          emit_err  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // IDLE always starts from a clean accumulator
    if (state_nxt == IDLE) begin
      acc_nxt = '0;
      cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_out <= 1'b0;
      data_out  <= '0;
      error_out <= 1'b0;
    end else begin
      ready_out <= emit_data || emit_err;
      if (emit_data) begin
        data_out  <= acc;
        error_out <= 1'b0;
      end else if (emit_err) begin
        data_out  <= '0;
        error_out <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_input_manager.sv
module tb_uart_input_manager;

  localparam int TMO = 50;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_frame_err = 1'b0;
  logic        ready_out;
  logic [15:0] data_out;
  logic        error_out;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  uart_input_manager #(
    .RESULT_SIZE    (4),
    .HEX_SIZE       (4),
    .ASCII_SIZE     (8),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_frame_err (rx_frame_err),
    .ready_out    (ready_out),
    .data_out     (data_out),
    .error_out    (error_out)
  );

  always #5 clk = ~clk;

  // ---------------- line-level reference model ----------------
  function automatic logic tb_is_hex(input logic [7:0] c);
    return (c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (c >= "a" && c <= "f");
  endfunction

  function automatic logic [3:0] tb_nib(input logic [7:0] c);
    int v;
    if (c >= "0" && c <= "9")      v = int'(c) - 48;
    else if (c >= "A" && c <= "F") v = int'(c) - 65 + 10;
    else                           v = int'(c) - 97 + 10;
    return 4'(v);
  endfunction

  // Model state: characters seen in the open line, whether any was bad,
  // the value of its digits, and consecutive quiet cycles since the last char.
  int          m_len = 0;
  int          m_idle = 0;
  logic        m_bad = 1'b0;
  logic [15:0] m_val = '0;
  logic        m_ready = 1'b0;
  logic [15:0] m_data = '0;
  logic        m_err = 1'b0;

  always @(posedge clk) begin : model
    int          len, idle;
    logic        bad, rdy, er;
    logic [15:0] val, dat;
    len = m_len; idle = m_idle; bad = m_bad; val = m_val;
    rdy = 1'b0; dat = m_data; er = m_err;
    if (reset) begin
      len = 0; idle = 0; bad = 1'b0; val = '0; dat = '0; er = 1'b0;
    end else if (rx_valid) begin
      idle = 0;
      if (!rx_frame_err && (rx_data == 8'h0D || rx_data == 8'h0A)) begin
        if (len > 0) begin
          rdy = 1'b1;
          if (bad || len > 4) begin dat = '0;  er = 1'b1; end
          else                begin dat = val; er = 1'b0; end
        end
        len = 0; bad = 1'b0; val = '0;
      end else begin
        len++;
        if (rx_frame_err || !tb_is_hex(rx_data)) bad = 1'b1;
        else val = {val[11:0], tb_nib(rx_data)};
      end
    end else if (len > 0) begin
      idle++;
      // a line may stay quiet for TMO cycles; one more quiet cycle rejects it
      if (idle > TMO) begin
        rdy = 1'b1; dat = '0; er = 1'b1;
        len = 0; bad = 1'b0; val = '0; idle = 0;
      end
    end
    m_len <= len; m_idle <= idle; m_bad <= bad; m_val <= val;
    m_ready <= rdy; m_data <= dat; m_err <= er;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({ready_out, data_out, error_out} !== {m_ready, m_data, m_err}) begin
        errors++;
        $display("FAIL model_cmp t=%0t got ready=%b data=%h err=%b expected ready=%b data=%h err=%b",
                 $time, ready_out, data_out, error_out, m_ready, m_data, m_err);
      end
    end
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_char(input logic [7:0] c, input logic fe, input int gap);
    rx_valid = 1'b1; rx_data = c; rx_frame_err = fe;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_frame_err = 1'b0;
    idle(gap);
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) send_char(s[i], 1'b0, gap);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic r, input logic [15:0] d, input logic e);
    checks++;
    if (ready_out !== r || data_out !== d || error_out !== e) begin
      errors++;
      $display("FAIL %s got ready=%b data=%h err=%b expected ready=%b data=%h err=%b",
               name, ready_out, data_out, error_out, r, d, e);
    end
  endtask

  task automatic send_random_line();
    string digits;
    int    n, r;
    logic [7:0] c;
    digits = "0123456789ABCDEFabcdef";
    n = $urandom_range(0, 6);
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 99);
      if (r < 75) begin
        send_char(digits[$urandom_range(0, 21)], 1'b0, $urandom_range(0, 6));
      end else if (r < 88) begin
        c = 8'($urandom_range(0, 255));
        if (tb_is_hex(c) || c == 8'h0D || c == 8'h0A) c = "G";
        send_char(c, 1'b0, $urandom_range(0, 6));
      end else if (r < 95) begin
        send_char(digits[$urandom_range(0, 21)], 1'b1, $urandom_range(0, 6));
      end else begin
        send_char(8'h0D, 1'b1, $urandom_range(0, 6));
      end
      if ($urandom_range(0, 99) < 3) idle($urandom_range(TMO - 2, TMO + 3));
      if ($urandom_range(0, 99) < 2) pulse_reset();
    end
    if ($urandom_range(0, 99) < 94)
      send_char(($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A, 1'b0, $urandom_range(0, 5));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    reset = 1'b1;
    idle(3);
    expect_out("reset_state", 1'b0, 16'h0000, 1'b0);
    reset = 1'b0;
    chk_en = 1'b1;
    idle(2);

    send_str("1A2F", 2);
    send_char(8'h0D, 1'b0, 0);
    expect_out("line_1A2F", 1'b1, 16'h1A2F, 1'b0);
    send_char("5", 1'b0, 0);  // coincides with the pulse
    expect_out("pulse_one_cycle", 1'b0, 16'h1A2F, 1'b0);
    idle(2);
    send_char(8'h0D, 1'b0, 0);
    expect_out("coincident_char_parsed", 1'b1, 16'h0005, 1'b0);
    idle(2);

    send_str("b", 2);
    send_char(8'h0D, 1'b0, 0);
    expect_out("line_b", 1'b1, 16'h000B, 1'b0);
    idle(2);
    send_char(8'h0A, 1'b0, 0);
    expect_out("lf_after_cr_ignored", 1'b0, 16'h000B, 1'b0);
    idle(2);

    send_str("12G4", 2);
    send_char(8'h0D, 1'b0, 0);
    expect_out("invalid_char", 1'b1, 16'h0000, 1'b1);
    idle(2);
    send_str("12345", 2);
    send_char(8'h0D, 1'b0, 0);
    expect_out("overflow", 1'b1, 16'h0000, 1'b1);
    idle(2);

    send_char("5", 1'b0, 2);
    send_char(8'h0D, 1'b0, 0);
    expect_out("recover_data", 1'b1, 16'h0005, 1'b0);
    idle(2);
    send_char("3", 1'b1, 2);
    send_str("44", 2);
    expect_out("frame_err_no_early_pulse", 1'b0, 16'h0005, 1'b0);
    send_char(8'h0D, 1'b0, 0);
    expect_out("frame_err_line", 1'b1, 16'h0000, 1'b1);
    idle(2);

    send_char("7", 1'b0, 0);
    idle(TMO);
    expect_out("timeout_not_yet", 1'b0, 16'h0000, 1'b1);
    idle(1);
    expect_out("timeout_fires", 1'b1, 16'h0000, 1'b1);
    idle(2);

    send_char("7", 1'b0, 0);
    idle(TMO - 2);
    send_char("8", 1'b0, 0);
    idle(TMO - 1);
    expect_out("timeout_rearmed", 1'b0, 16'h0000, 1'b1);
    send_char(8'h0D, 1'b0, 0);
    expect_out("line_78", 1'b1, 16'h0078, 1'b0);
    idle(2);

    send_str("AB", 2);
    pulse_reset();
    expect_out("reset_mid_line", 1'b0, 16'h0000, 1'b0);
    send_str("CD", 2);
    send_char(8'h0D, 1'b0, 0);
    expect_out("line_after_reset", 1'b1, 16'h00CD, 1'b0);
    idle(3);

    for (int l = 0; l < 250; l++) send_random_line();
    idle(TMO + 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
